// File: rtl/seg_codes_pkg.sv
// seg_codes_pkg: decoder data/mode code pairs, message codes and arbiter states.
package seg_codes_pkg;
    localparam logic [3:0] HEX_MODE   = 4'b1000;
    localparam logic [3:0] SPC_MODE   = 4'b0000;
    localparam logic [3:0] CODE_BLANK = 4'b0001;
    localparam logic [3:0] CODE_MINUS = 4'b0100;
    localparam logic [3:0] CODE_DP    = 4'b0010;
    localparam logic [3:0] CODE_F     = 4'b1000;
    typedef enum logic [1:0] {MSG_BLANK, MSG_MINUS, MSG_FAULT, MSG_DP} msg_code_t;
    typedef enum logic {ST_VAL, ST_MSG} state_t;
    function automatic logic [3:0] msg_data(input msg_code_t c);
        return (c == MSG_MINUS) ? CODE_MINUS : (c == MSG_FAULT) ? CODE_F :
               (c == MSG_DP) ? CODE_DP : CODE_BLANK;
    endfunction
endpackage

// File: rtl/seg_hold_timer.sv
// seg_hold_timer: down-counter loaded with CYCLES-1, stops at zero and flags it.
module seg_hold_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else if (i_load) r_cnt <= W'(CYCLES - 1);
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares a seven-segment bank between a numeric value
// source and a held, optionally blinking message requester.
module seg_display_arbiter #(
    parameter int NUM_DIGITS   = 4,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] val_data,
    input  logic                    val_neg,
    input  logic                    val_valid,
    input  logic                    blank_lz,
    input  logic                    msg_req,
    input  logic [1:0]              msg_code,
    input  logic                    msg_blink,
    output logic                    msg_ack,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] dig_data,
    output logic [4*NUM_DIGITS-1:0] dig_mode
);
    import seg_codes_pkg::*;
    state_t r_state, w_next;
    msg_code_t r_code, w_code;
    logic r_blink, w_blink, r_phase, w_phase, r_ack, r_busy;
    logic w_accept, w_hold_zero, w_blink_zero, w_blink_reload, w_lead;
    logic [4*NUM_DIGITS-1:0] r_data, r_mode, w_data, w_mode;

    seg_hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
        .clk(clk), .reset(reset), .i_load(w_accept),
        .i_en(r_state == ST_MSG), .o_zero(w_hold_zero)
    );
    seg_hold_timer #(.CYCLES(BLINK_CYCLES)) u_blink (
        .clk(clk), .reset(reset), .i_load(w_accept || w_blink_reload),
        .i_en(r_state == ST_MSG), .o_zero(w_blink_zero)
    );

    // Display is built from next-cycle state so the registered digits switch on the same edge as the FSM.
    always_comb begin
        w_accept       = (r_state == ST_VAL) && msg_req;
        w_next         = w_accept ? ST_MSG : (r_state == ST_MSG && w_hold_zero) ? ST_VAL : r_state;
        w_code         = w_accept ? msg_code_t'(msg_code) : r_code;
        w_blink        = w_accept ? msg_blink : r_blink;
        w_blink_reload = (r_state == ST_MSG) && r_blink && w_blink_zero;
        w_phase        = w_accept ? 1'b1 : w_blink_reload ? ~r_phase : r_phase;
        w_lead         = 1'b1;
        w_data         = '0;
        w_mode         = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_mode[4*i +: 4] = SPC_MODE;
            if (w_next == ST_MSG)
                w_data[4*i +: 4] = (w_blink && !w_phase) ? CODE_BLANK : msg_data(w_code);
            else if (!val_valid)
                w_data[4*i +: 4] = CODE_BLANK;
            else if (i == NUM_DIGITS - 1 && val_neg)
                w_data[4*i +: 4] = CODE_MINUS;
            else if (blank_lz && w_lead && val_data[4*i +: 4] == 4'd0 && i != 0)
                w_data[4*i +: 4] = CODE_BLANK;
            else begin
                w_data[4*i +: 4] = val_data[4*i +: 4];
                w_mode[4*i +: 4] = HEX_MODE;
                w_lead           = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_VAL;
            r_code  <= MSG_BLANK;
            r_blink <= 1'b0;
            r_phase <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= {NUM_DIGITS{CODE_BLANK}};
            r_mode  <= {NUM_DIGITS{SPC_MODE}};
        end else begin
            r_state <= w_next;
            r_code  <= w_code;
            r_blink <= w_blink;
            r_phase <= w_phase;
            r_ack   <= w_accept;
            r_busy  <= (w_next == ST_MSG);
            r_data  <= w_data;
            r_mode  <= w_mode;
        end
    end

    assign msg_ack  = r_ack;
    assign busy     = r_busy;
    assign dig_data = r_data;
    assign dig_mode = r_mode;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: scoreboard bench; a cycle model queues the expected
// {ack, busy, data, mode} per edge and each scenario pops and compares it.
module tb_seg_display_arbiter;
    localparam int ND = 4, HOLD = 8, BLINK = 2;
    logic clk = 0, reset = 1;
    logic [15:0] val_data = 0;
    logic val_neg = 0, val_valid = 0, blank_lz = 0, msg_req = 0, msg_blink = 0;
    logic [1:0] msg_code = 0;
    logic msg_ack, busy;
    logic [15:0] dig_data, dig_mode;
    int checks = 0, failures = 0;
    logic [33:0] sb[$];
    logic [33:0] exp_v, got_v;
    bit m_busy, m_blink;
    int m_left, m_k;
    logic [1:0] m_code;

    always #5 clk = ~clk;

    seg_display_arbiter #(.NUM_DIGITS(ND), .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
        .clk(clk), .reset(reset), .val_data(val_data), .val_neg(val_neg),
        .val_valid(val_valid), .blank_lz(blank_lz), .msg_req(msg_req),
        .msg_code(msg_code), .msg_blink(msg_blink), .msg_ack(msg_ack),
        .busy(busy), .dig_data(dig_data), .dig_mode(dig_mode)
    );

    function automatic logic [31:0] val_model(input logic [15:0] d, input bit neg, valid, lz);
        logic [15:0] od, om;
        int j = 0;
        if (!valid) return {16'h1111, 16'h0000};
        for (int i = 0; i <= (neg ? 2 : 3); i++) if (d[4*i +: 4] != 0) j = i;
        for (int i = 0; i < 4; i++) begin
            if (neg && i == 3) begin od[4*i +: 4] = 4'b0100; om[4*i +: 4] = 4'b0000; end
            else if (lz && i > j) begin od[4*i +: 4] = 4'b0001; om[4*i +: 4] = 4'b0000; end
            else begin od[4*i +: 4] = d[4*i +: 4]; om[4*i +: 4] = 4'b1000; end
        end
        return {od, om};
    endfunction

    function automatic logic [3:0] msg_nib(input logic [1:0] c);
        case (c)
            2'd1: return 4'b0100;
            2'd2: return 4'b1000;
            2'd3: return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_blink = 0; m_left = 0; m_k = 0; m_code = 0;
        sb.delete();
    endtask

    // Advance the model one edge with the current inputs, queue expectation, clock the DUT.
    task automatic tick();
        bit acc;
        logic [31:0] disp;
        acc = !m_busy && msg_req;
        if (acc) begin
            m_busy = 1; m_left = HOLD - 1; m_k = 0; m_code = msg_code; m_blink = msg_blink;
        end else if (m_busy) begin
            if (m_left == 0) m_busy = 0;
            else begin m_left--; m_k++; end
        end
        if (m_busy)
            disp = (m_blink && ((m_k / BLINK) % 2 == 1)) ? {16'h1111, 16'h0000} : {{4{msg_nib(m_code)}}, 16'h0000};
        else
            disp = val_model(val_data, val_neg, val_valid, blank_lz);
        sb.push_back({acc, m_busy, disp});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({msg_ack, busy, dig_data, dig_mode} !== {2'b00, 16'h1111, 16'h0000}) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", {msg_ack, busy, dig_data, dig_mode}, {2'b00, 16'h1111, 16'h0000});
        end
        reset = 0; model_reset();
        val_valid = 1; val_data = 16'h9876;
        repeat (2) tick();
        sb.delete();
        #2 reset = 1;
        #1;
        checks++;
        if ({msg_ack, busy, dig_data, dig_mode} !== {2'b00, 16'h1111, 16'h0000}) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", {msg_ack, busy, dig_data, dig_mode}, {2'b00, 16'h1111, 16'h0000});
        end
        @(posedge clk);
        #2 reset = 0; model_reset();
        val_data = 16'h1234;
        tick();
        exp_v = sb.pop_front();
        got_v = {msg_ack, busy, dig_data, dig_mode};
        checks++;
        if (got_v !== exp_v || dig_data !== 16'h1234 || dig_mode !== 16'h8888) begin
            failures++;
            $display("FAIL value_1234 got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_lz();
        logic [15:0] pat [3] = '{16'h0050, 16'h0000, 16'h0007};
        logic [31:0] want [3] = '{{16'h1150, 16'h0088}, {16'h1110, 16'h0008}, {16'h4117, 16'h0008}};
        blank_lz = 1;
        for (int i = 0; i < 3; i++) begin
            val_data = pat[i]; val_neg = (i == 2);
            tick();
            exp_v = sb.pop_front();
            got_v = {msg_ack, busy, dig_data, dig_mode};
            checks++;
            if (got_v !== exp_v || got_v[31:0] !== want[i]) begin
                failures++;
                $display("FAIL lz_%0d got=%h exp=%h", i, got_v, {exp_v[33:32], want[i]});
            end
        end
        val_data = 16'h0A30; val_neg = 0;
        tick();
        exp_v = sb.pop_front();
        got_v = {msg_ack, busy, dig_data, dig_mode};
        checks++;
        if (got_v !== exp_v) begin failures++; $display("FAIL lz_0a30 got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic run_msg(input string name, input logic [1:0] code, input bit blink, input int n);
        int acks = 0, busy_cnt = 0;
        msg_req = 1; msg_code = code; msg_blink = blink;
        for (int i = 0; i < n; i++) begin
            tick();
            if (msg_ack) begin msg_req = 0; msg_code = ~code; msg_blink = ~blink; end
            acks += int'(msg_ack); busy_cnt += int'(busy);
            exp_v = sb.pop_front();
            got_v = {msg_ack, busy, dig_data, dig_mode};
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got_v, exp_v); end
        end
        checks++;
        if (acks != 1 || busy_cnt != HOLD) begin
            failures++;
            $display("FAIL %s_counts acks=%0d busy=%0d exp acks=1 busy=%0d", name, acks, busy_cnt, HOLD);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0, last = -1;
        msg_req = 1; msg_code = 2'd3; msg_blink = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = {msg_ack, busy, dig_data, dig_mode};
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL b2b cyc%0d got=%h exp=%h", i, got_v, exp_v); end
            if (msg_ack) begin
                checks++;
                if (last >= 0 && i - last != HOLD + 1) begin
                    failures++;
                    $display("FAIL b2b_spacing got=%0d exp=%0d", i - last, HOLD + 1);
                end
                last = i; acks++;
            end
        end
        checks++;
        if (acks != 4) begin failures++; $display("FAIL b2b_acks got=%0d exp=4", acks); end
        msg_req = 0;
        for (int i = 0; i < 12 && m_busy; i++) begin tick(); void'(sb.pop_front()); end
    endtask

    task automatic test_reset_in_msg();
        msg_req = 1; msg_code = 2'd2; msg_blink = 0;
        tick();
        msg_req = 0;
        repeat (3) tick();
        sb.delete();
        #2 reset = 1;
        #1;
        checks++;
        if ({msg_ack, busy, dig_data, dig_mode} !== {2'b00, 16'h1111, 16'h0000}) begin
            failures++;
            $display("FAIL reset_msg got=%h exp=%h", {msg_ack, busy, dig_data, dig_mode}, {2'b00, 16'h1111, 16'h0000});
        end
        @(posedge clk);
        #2 reset = 0; model_reset();
        for (int i = 0; i < 6; i++) begin
            msg_req = (i == 4);
            tick();
            exp_v = sb.pop_front();
            got_v = {msg_ack, busy, dig_data, dig_mode};
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL post_reset cyc%0d got=%h exp=%h", i, got_v, exp_v); end
        end
        msg_req = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lz();
        blank_lz = 0; val_neg = 0; val_data = 16'hBEEF;
        run_msg("msg_fault", 2'd2, 1'b0, HOLD + 3);
        run_msg("msg_blink", 2'd1, 1'b1, HOLD + 3);
        test_back_to_back();
        test_reset_in_msg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Owns a bank of NUM_DIGITS seven-segment decoder instances.
- Each decoder takes a 4-bit data code and a 4-bit mode code.
- Shares the display between a continuous numeric value source and a priority message requester.
- Message path uses a req/ack handshake, a timed hold and optional blinking; leading-zero suppression is applied to the value path.

Parameters:
- NUM_DIGITS, 4, number of decoder digits driven (min 2).
- HOLD_CYCLES, 50000000, clk cycles a message stays on screen (min 2).
- BLINK_CYCLES, 25000000, clk cycles per blink half-period (min 1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- val_data  in  4*NUM_DIGITS  hex nibbles; the top nibble is the MSD.
- val_neg  in  1  value negative; MSD shows minus.
- val_valid  in  1  value source present; 0 shows all blank.
- blank_lz  in  1  enable leading-zero suppression.
- msg_req  in  1  message request, held high until msg_ack.
- msg_code  in  2  0=all blank, 1=all minus, 2=all F (fault), 3=all decimal point.
- msg_blink  in  1  blink the message, sampled at accept.
- msg_ack  out  1  one-cycle accept pulse.
- busy  out  1  high while a message owns the display.
- dig_data  out  4*NUM_DIGITS  data code per digit to the decoders.
- dig_mode  out  4*NUM_DIGITS  mode code per digit to the decoders.

Behaviour:
- Digit code pairs (data/mode):
  - hex nibble = nibble/1000
  - blank = 0001/0000
  - minus = 0100/0000
  - dp = 0010/0000
  - F = 1000/0000
  - No other pair is ever emitted.
- Reset (async): state VAL, every digit = blank, msg_ack=0, busy=0, hold and blink counters=0, latched msg_code/msg_blink=0.
- Reset during MSG aborts the message silently; no ack follows.
- All outputs are registered. dig_* reflect the inputs sampled at edge N, visible after edge N (1-cycle latency).
- FSM states VAL and MSG:
  - VAL -> MSG when msg_req=1 at the edge. Same edge: msg_ack=1 for exactly that cycle, latch msg_code/msg_blink, hold counter=HOLD_CYCLES-1, blink counter=0, blink phase=on, busy=1.
  - MSG: the hold counter decrements each cycle. At edge with counter=0 -> VAL, busy=0.
  - msg_req during MSG is not acked. The next accept occurs no earlier than the first edge in VAL, so there is at least one VAL cycle (value shown) between messages.
  - Message visible for exactly HOLD_CYCLES cycles.
- Value display (VAL):
  - val_valid=0: all blank.
  - Otherwise digit i = hex(val_data[4i+3:4i]).
  - val_neg=1: MSD forced to minus regardless of its nibble.
  - blank_lz=1: scanning from the MSD (or MSD-1 when val_neg), zero nibbles are blanked until the first nonzero nibble. Digit 0 is never blanked.
  - Example, 4 digits: 0x0050 -> blank,blank,5,0. 0x0000 -> blank,blank,blank,0. neg 0x0007 -> minus,blank,blank,7.
- Message display (MSG):
  - All digits show the code for the latched msg_code.
  - If the latched blink=1, the blink counter counts 0..BLINK_CYCLES-1 and toggles the phase on wrap; while phase=off, all digits are blank.
  - Message content changes on msg_code after accept are ignored.
- Simultaneous msg_req and hold expiry: expiry wins, return to VAL; the request is acked on the following edge.
- Counters never wrap below zero and are sized by $clog2 of their parameter.

Decomposition:
- Package seg_codes_pkg holds:
  - the localparams for the data/mode code pairs (HEX_MODE, SPC_MODE, CODE_BLANK, CODE_MINUS, CODE_DP, CODE_F);
  - the msg_code enumeration;
  - the FSM state typedef.
- One sub-module, seg_hold_timer: a loadable down-counter with a zero flag, instanced for the hold and for the blink period.
- The leading-zero logic stays inline.

Test Plan (NUM_DIGITS=4, HOLD_CYCLES=8, BLINK_CYCLES=2):
- Assert reset mid-run -> all digits 0001/0000 immediately, busy=0, msg_ack=0. Release, val_data=16'h1234, valid=1 -> after 1 edge dig_data=1,2,3,4 MSD-first, all modes 1000.
- blank_lz=1, val_data=16'h0050, then 16'h0000, then val_neg=1 with 16'h0007 -> blank,blank,5,0; then blank,blank,blank,0; then minus,blank,blank,7.
- msg_req=1, code=2, blink=0 -> msg_ack high exactly 1 cycle, busy=1, all digits 1000/0000 for exactly 8 cycles, then the value returns and busy=0.
- code=1, blink=1 -> digits alternate minus for 2 cycles, blank for 2 cycles, over 8 cycles, starting with minus.
- Hold msg_req high continuously -> ack pulses spaced by 8 message cycles plus 1 VAL cycle. No ack while busy=1.
- Assert reset on hold cycle 4 of a message -> display blank, busy=0, no further msg_ack until a new request after release.
